// File: rtl/cache_mem_ctrl_if.sv
// Cache-side and RAM-side signal bundle for the cache memory controller.
// The controller connects through the slave modport; the caches/RAM
// environment (or a testbench standing in for it) uses the master modport.
interface cache_mem_ctrl_if;
    // instruction cache side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    // data cache side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    // single-ported RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder for the instruction and data caches. Arbitrates the
// two requesters onto one single-ported RAM, one access at a time, and
// answers the granted side with the wait/load handshake.
module cache_mem_ctrl #(
    parameter int D_PRIORITY = 0  // 0: round-robin on ties, 1: data side wins ties
) (
    input  logic            CLK,
    input  logic            RST,
    cache_mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    state_t      state;
    state_t      next_state;
    grant_t      last_grant;

    // request registers captured when an access is granted
    logic [31:0] lat_addr;
    logic [31:0] lat_store;
    logic        lat_wr;

    logic        d_req;
    logic        latch_en;
    logic        grant_d;

    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;

    assign d_req = bus.dREN | bus.dWEN;

    // Next-state, arbitration and all handshake/RAM outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        next_state = state;
        latch_en   = 1'b0;
        grant_d    = 1'b0;
        iwait      = 1'b1;
        iload      = 32'h0;
        dwait      = 1'b1;
        dload      = 32'h0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = 32'h0;
        ram_store  = 32'h0;

        case (state)
            IDLE: begin
                if (bus.iREN && d_req) begin
                    latch_en = 1'b1;
                    grant_d  = (D_PRIORITY != 0) || (last_grant == GRANT_I);
                end else if (d_req) begin
                    latch_en = 1'b1;
                    grant_d  = 1'b1;
                end else if (bus.iREN) begin
                    latch_en = 1'b1;
                end
                if (latch_en) begin
                    next_state = grant_d ? DACC : IACC;
                end
            end

            IACC: begin
                if (!bus.iREN) begin
                    // requester gave up: no strobe, ramready ignored
                    next_state = IDLE;
                end else begin
                    ram_ren  = 1'b1;
                    ram_addr = lat_addr & 32'hFFFF_FFFC;
                    if (bus.ramready) begin
                        iwait      = 1'b0;
                        iload      = bus.ramload;
                        next_state = IDLE;
                    end
                end
            end

            DACC: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ram_ren   = ~lat_wr;
                    ram_wen   = lat_wr;
                    ram_addr  = lat_addr & 32'hFFFF_FFFC;
                    ram_store = lat_store;
                    if (bus.ramready) begin
                        dwait      = 1'b0;
                        dload      = lat_wr ? 32'h0 : bus.ramload;
                        next_state = IDLE;
                    end
                end
            end

            default: next_state = IDLE;
        endcase

        // reset silences the RAM and both requesters immediately
        if (RST) begin
            iwait     = 1'b1;
            iload     = 32'h0;
            dwait     = 1'b1;
            dload     = 32'h0;
            ram_ren   = 1'b0;
            ram_wen   = 1'b0;
            ram_addr  = 32'h0;
            ram_store = 32'h0;
        end
    end

    // State, grant history and request registers.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before this edge, independent of statement order.
        if (RST) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            lat_addr   <= 32'h0;
            lat_store  <= 32'h0;
            lat_wr     <= 1'b0;
        end else begin
            state <= next_state;
            if (latch_en) begin
                last_grant <= grant_d ? GRANT_D : GRANT_I;
                lat_addr   <= grant_d ? bus.daddr : bus.iaddr;
                lat_store  <= grant_d ? bus.dstore : 32'h0;
                lat_wr     <= grant_d & bus.dWEN;
            end
        end
    end

    assign bus.iwait    = iwait;
    assign bus.iload    = iload;
    assign bus.dwait    = dwait;
    assign bus.dload    = dload;
    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench: two controllers (round-robin and data-priority) see
// identical stimulus; each is compared every cycle against a
// transaction-level reference model, with directed scenarios followed by
// randomized traffic.
module tb_cache_mem_ctrl;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    cache_mem_ctrl_if bus0 ();
    cache_mem_ctrl_if bus1 ();

    cache_mem_ctrl #(.D_PRIORITY(0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0.slave));
    cache_mem_ctrl #(.D_PRIORITY(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));

    // shared stimulus
    logic        s_iren, s_dren, s_dwen, s_ready;
    logic [31:0] s_iaddr, s_daddr, s_dstore, s_load;

    // observed outputs, index = instance (0: round-robin, 1: data priority)
    logic        o_iwait [2];
    logic        o_dwait [2];
    logic        o_ren   [2];
    logic        o_wen   [2];
    logic [31:0] o_iload [2];
    logic [31:0] o_dload [2];
    logic [31:0] o_addr  [2];
    logic [31:0] o_store [2];

    assign o_iwait[0] = bus0.iwait;    assign o_iwait[1] = bus1.iwait;
    assign o_dwait[0] = bus0.dwait;    assign o_dwait[1] = bus1.dwait;
    assign o_ren[0]   = bus0.ramREN;   assign o_ren[1]   = bus1.ramREN;
    assign o_wen[0]   = bus0.ramWEN;   assign o_wen[1]   = bus1.ramWEN;
    assign o_iload[0] = bus0.iload;    assign o_iload[1] = bus1.iload;
    assign o_dload[0] = bus0.dload;    assign o_dload[1] = bus1.dload;
    assign o_addr[0]  = bus0.ramaddr;  assign o_addr[1]  = bus1.ramaddr;
    assign o_store[0] = bus0.ramstore; assign o_store[1] = bus1.ramstore;

    // reference model: the one outstanding transaction per instance
    bit          m_busy [2];
    bit          m_side [2];   // 0 = instruction, 1 = data
    bit          m_last [2];   // side of the most recent grant
    bit          m_wr   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_store[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply();
        bus0.iREN = s_iren;   bus1.iREN = s_iren;
        bus0.iaddr = s_iaddr; bus1.iaddr = s_iaddr;
        bus0.dREN = s_dren;   bus1.dREN = s_dren;
        bus0.dWEN = s_dwen;   bus1.dWEN = s_dwen;
        bus0.daddr = s_daddr; bus1.daddr = s_daddr;
        bus0.dstore = s_dstore; bus1.dstore = s_dstore;
        bus0.ramload = s_load;  bus1.ramload = s_load;
        bus0.ramready = s_ready; bus1.ramready = s_ready;
    endtask

    // Compare both instances' outputs with what the model predicts now.
    task automatic check_outputs();
        for (int p = 0; p < 2; p++) begin
            logic        e_iwait, e_dwait, e_ren, e_wen, held, chk_addr, chk_store;
            logic [31:0] e_iload, e_dload, e_addr, e_store;
            e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
            e_iload = 32'h0; e_dload = 32'h0; e_addr = 32'h0; e_store = 32'h0;
            chk_addr = RST; chk_store = RST;
            if (!RST && m_busy[p]) begin
                held = m_side[p] ? (s_dren | s_dwen) : s_iren;
                if (held) begin
                    e_addr   = {m_addr[p][31:2], 2'b00};
                    chk_addr = 1'b1;
                    if (m_side[p]) begin
                        e_ren = !m_wr[p];
                        e_wen = m_wr[p];
                        e_store = m_store[p];
                        chk_store = m_wr[p];
                    end else begin
                        e_ren = 1'b1;
                    end
                    if (s_ready) begin
                        if (m_side[p]) begin
                            e_dwait = 1'b0;
                            e_dload = m_wr[p] ? 32'h0 : s_load;
                        end else begin
                            e_iwait = 1'b0;
                            e_iload = s_load;
                        end
                    end
                end
            end
            check($sformatf("p%0d iwait", p), o_iwait[p], e_iwait);
            check($sformatf("p%0d dwait", p), o_dwait[p], e_dwait);
            check($sformatf("p%0d iload", p), o_iload[p], e_iload);
            check($sformatf("p%0d dload", p), o_dload[p], e_dload);
            check($sformatf("p%0d ramREN", p), o_ren[p], e_ren);
            check($sformatf("p%0d ramWEN", p), o_wen[p], e_wen);
            if (chk_addr) check($sformatf("p%0d ramaddr", p), o_addr[p], e_addr);
            if (chk_store) check($sformatf("p%0d ramstore", p), o_store[p], e_store);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        for (int p = 0; p < 2; p++) begin
            bit d_any;
            d_any = s_dren | s_dwen;
            if (RST) begin
                m_busy[p] = 0; m_last[p] = 0; m_wr[p] = 0;
                m_addr[p] = 32'h0; m_store[p] = 32'h0;
            end else if (!m_busy[p]) begin
                if (d_any || s_iren) begin
                    m_side[p]  = d_any && (!s_iren || p == 1 || !m_last[p]);
                    m_busy[p]  = 1;
                    m_last[p]  = m_side[p];
                    m_addr[p]  = m_side[p] ? s_daddr : s_iaddr;
                    m_store[p] = m_side[p] ? s_dstore : 32'h0;
                    m_wr[p]    = m_side[p] && s_dwen;
                end
            end else begin
                if (!(m_side[p] ? d_any : s_iren) || s_ready) m_busy[p] = 0;
            end
        end
    endtask

    // One clock cycle: drive, settle, compare, clock, update model.
    task automatic cycle();
        apply();
        #1;
        check_outputs();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        s_iren = 0; s_dren = 0; s_dwen = 0; s_ready = 0;
    endtask

    initial begin
        s_iaddr = 0; s_daddr = 0; s_dstore = 0; s_load = 0;
        idle_inputs();
        RST = 1'b1;
        @(negedge CLK);
        cycle();
        cycle();
        RST = 1'b0;

        // single fetch: ramready at cycle 3
        s_iren = 1; s_iaddr = 32'h0000_0044;
        cycle();
        apply(); #1;
        check("fetch ramREN c1", o_ren[0], 1);
        check("fetch ramaddr c1", o_addr[0], 32'h44);
        cycle();
        cycle();
        s_ready = 1; s_load = 32'hDEAD_BEEF;
        apply(); #1;
        check("fetch iwait c3", o_iwait[0], 0);
        check("fetch iload c3", o_iload[0], 32'hDEAD_BEEF);
        cycle();
        idle_inputs();
        apply(); #1;
        check("fetch idle c4", o_ren[0], 0);
        cycle();

        // tie: round-robin alternates D, I, D; data priority stays on D
        s_iren = 1; s_dren = 1; s_iaddr = 32'h200; s_daddr = 32'h300;
        for (int k = 0; k < 6; k++) begin
            s_ready = (k % 2 == 1);
            s_load = $urandom;
            if (k % 2 == 1) begin
                apply(); #1;
                check("rr ramaddr", o_addr[0], (k == 3) ? 32'h200 : 32'h300);
                check("prio ramaddr", o_addr[1], 32'h300);
            end
            cycle();
        end
        idle_inputs();
        cycle();

        // write wins over read, address aligned, dload stays 0
        s_dren = 1; s_dwen = 1; s_daddr = 32'h103; s_dstore = 32'h1234_5678;
        cycle();
        s_ready = 1; s_load = 32'hCAFE_F00D;
        apply(); #1;
        check("wr ramWEN", o_wen[0], 1);
        check("wr ramREN", o_ren[0], 0);
        check("wr ramaddr", o_addr[0], 32'h100);
        check("wr ramstore", o_store[0], 32'h1234_5678);
        check("wr dwait", o_dwait[0], 0);
        check("wr dload", o_dload[0], 0);
        cycle();
        idle_inputs();
        cycle();

        // abort: iREN drops mid-access, stray ramready next cycle
        s_iren = 1; s_iaddr = 32'h80;
        cycle();
        cycle();
        s_iren = 0;
        apply(); #1;
        check("abort ramREN", o_ren[0], 0);
        check("abort iwait", o_iwait[0], 1);
        cycle();
        s_ready = 1;
        apply(); #1;
        check("stray ready iwait", o_iwait[0], 1);
        cycle();
        idle_inputs();
        cycle();

        // reset during a data write, then the next tie goes to D
        s_dwen = 1; s_daddr = 32'h40; s_dstore = 32'h5555_AAAA;
        cycle();
        apply(); #1;
        check("rstmid ramWEN before", o_wen[0], 1);
        cycle();
        RST = 1'b1;
        apply(); #1;
        check("rstmid ramWEN", o_wen[0], 0);
        check("rstmid dwait", o_dwait[0], 1);
        cycle();
        RST = 1'b0;
        s_dwen = 0; s_iren = 1; s_dren = 1; s_iaddr = 32'h600; s_daddr = 32'h700;
        cycle();
        s_ready = 1;
        apply(); #1;
        check("post-rst tie ramaddr", o_addr[0], 32'h700);
        cycle();
        idle_inputs();
        cycle();

        // strict priority: held dREN starves I until it drops
        s_iren = 1; s_dren = 1; s_iaddr = 32'h900; s_daddr = 32'hA00;
        for (int k = 0; k < 8; k++) begin
            s_ready = (k % 2 == 1);
            cycle();
        end
        s_dren = 0;
        for (int k = 0; k < 4; k++) begin
            s_ready = (k % 2 == 1);
            cycle();
        end
        idle_inputs();
        cycle();

        // randomized traffic with request persistence and occasional reset
        for (int n = 0; n < 3000; n++) begin
            s_iren  = s_iren ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            s_dren  = s_dren ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            s_dwen  = s_dwen ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) s_iaddr = $urandom;
            if ($urandom_range(0, 4) == 0) s_daddr = $urandom;
            if ($urandom_range(0, 4) == 0) s_dstore = $urandom;
            s_ready = ($urandom_range(0, 2) == 0);
            s_load  = $urandom;
            RST     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
